cc_wb_arbiter_mux: RTL
======================

Name: cc_wb_arbiter_mux

Overview:
- Next-generation writeback-bus selector.
- Replaces the fixed 2:1 ALU/main-memory select with an N-source arbitrated mux.
- Round-robin fairness, a registered output stage and a valid/ready handshake toward the register-file write port.
- Sits between the execution/memory units and the register file.
- Each source presents data plus a destination register address and holds it until granted.

Parameters:
- DATAWIDTH_BUS, 32: width of each writeback data word.
- NUM_SOURCES, 4: number of requesting units, legal range 2..8.
- REGADDR_WIDTH, 5: destination register address width.
- SRC_WIDTH, $clog2(NUM_SOURCES): width of the source index. Derived; do not override.

Ports:
- CC_WB_CLOCK_50  in  1  system clock; all state on the rising edge.
- CC_WB_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_WB_req_InBUS  in  NUM_SOURCES  per-source write request; held until the matching grant.
- CC_WB_data_InBUS  in  NUM_SOURCES*DATAWIDTH_BUS  packed source data; source i in slice [i*DW +: DW].
- CC_WB_addr_InBUS  in  NUM_SOURCES*REGADDR_WIDTH  packed destination addresses; same packing.
- CC_WB_grant_OutBUS  out  NUM_SOURCES  one-hot combinational grant; source drops or advances its request next cycle.
- CC_WB_data_OutBUS  out  DATAWIDTH_BUS  registered selected data.
- CC_WB_addr_OutBUS  out  REGADDR_WIDTH  registered selected address.
- CC_WB_src_OutBUS  out  SRC_WIDTH  registered index of the winning source.
- CC_WB_valid_Out  out  1  output register holds an unconsumed entry.
- CC_WB_ready_In  in  1  consumer accepts the entry this cycle.

Behaviour:
- Reset, asynchronous on CC_WB_RESET_InLow=0, any time including mid-transfer:
  - valid=0; data, addr and src all zero; RR pointer=0.
  - grant is forced all-zero while reset is asserted.
  - Any pending entry is discarded.
- States: EMPTY (valid=0) and FULL (valid=1).
- Slot free condition: free = !valid || ready. This allows back-to-back transfers with zero bubble.
- Grant rule:
  - Grant is issued only when free=1 and req≠0.
  - Exactly one grant bit is set: the first requesting source scanning from the RR pointer upward, wrapping at NUM_SOURCES-1 → 0.
- On a grant to source k, at the next clock edge:
  - data/addr are loaded from slice k; src=k; valid=1.
  - RR pointer = (k+1) mod NUM_SOURCES. Wrap from NUM_SOURCES-1 to 0 is required.
- No grant with free=1: valid clears if ready was high; otherwise the state is unchanged.
- FULL with ready=0:
  - All outputs hold; grant=0 (stall).
  - Pointer holds.
- Simultaneous accept and new grant in the same cycle: the new entry replaces the old one; valid stays 1.
- Latency: one cycle from grant to valid output. Throughput: one entry per cycle.
- Requests whose address is 0 are still arbitrated and forwarded. Suppressing writes to register 0 is the register file's job.
- No combinational path from CC_WB_data_InBUS to CC_WB_data_OutBUS.

Optional Feature:
- Macro: CC_WB_FIXED_PRIORITY_EN.
- Defined:
  - Fixed priority; the lowest index wins (source 0 = main-memory load, highest).
  - The RR pointer is not implemented; behaviour matches the legacy "memory beats ALU" rule.
- Undefined: round-robin arbitration as above.

Decomposition:
- Shared package cc_wb_pkg holds:
  - default widths: CC_WB_DATAWIDTH=32, CC_WB_REGADDR_WIDTH=5;
  - source index constants: SRC_MEM=0, SRC_ALU=1, SRC_MUL=2, SRC_CSR=3;
  - state enum {WB_EMPTY, WB_FULL}.
- One sub-module is natural: cc_rr_arbiter, a combinational rotate-priority encoder with inputs req and pointer, outputs one-hot grant and index. It is reusable by other arbitration points.

Test Plan:
- Reset mid-transfer: valid=1 with data 0xDEADBEEF, ready=0; pulse RESET_InLow low → valid=0, data=0, grant=0 immediately; after release the pointer restarts at 0.
- Single source: req=4'b0010, data1=0x12345678, addr1=7, ready=1 → grant=0010 in the same cycle; next cycle data=0x12345678, addr=7, src=1, valid=1.
- Round-robin fairness: req=4'b1111 held, ready=1 → grants 0001, 0010, 0100, 1000, 0001 (wrap) on consecutive cycles; valid never drops.
- Backpressure: valid=1, ready=0 for 3 cycles with req=4'b0100 → grant=0 and outputs stable; in the cycle ready=1 → grant=0100, and source 2 data appears next cycle with no bubble.
- Skip non-requesters: pointer=3, req=4'b0101 → grant=0001, then pointer=1; next cycle grant=0100.
- With CC_WB_FIXED_PRIORITY_EN defined: req=4'b0011 held for 4 cycles → grant=0001 every cycle; source 1 is starved until req[0] drops.

Source files
------------

// File: rtl/cc_wb_pkg.sv
// Shared definitions for the writeback-bus selector and its arbiter.
// Holds default widths, well-known source indices and the output-slot state type.
package cc_wb_pkg;

  localparam int CC_WB_DATAWIDTH     = 32;
  localparam int CC_WB_REGADDR_WIDTH = 5;

  // Fixed source slots; index 0 is the main-memory load path (highest legacy priority).
  localparam int SRC_MEM = 0;
  localparam int SRC_ALU = 1;
  localparam int SRC_MUL = 2;
  localparam int SRC_CSR = 3;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  // Next round-robin start position after index idx among n sources.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cc_rr_arbiter.sv
// Combinational rotate-priority encoder: picks the first requester at or
// above i_ptr, wrapping at NUM_SOURCES-1. Produces a one-hot grant and its index.
// Reusable at any arbitration point; tie i_ptr to zero for fixed priority.
module cc_rr_arbiter
  import cc_wb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int SRC_WIDTH   = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] i_req,
  input  logic [SRC_WIDTH-1:0]   i_ptr,
  output logic [NUM_SOURCES-1:0] o_grant,
  output logic [SRC_WIDTH-1:0]   o_idx
);

  // Scan offsets 0..N-1 from the pointer; the first requesting candidate wins.
  always_comb begin
    logic w_found;
    w_found = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int off = 0; off < NUM_SOURCES; off++) begin
      for (int j = 0; j < NUM_SOURCES; j++) begin
        if (!w_found && i_req[j] &&
            (j == ((int'(i_ptr) + off) % NUM_SOURCES))) begin
          w_found    = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = SRC_WIDTH'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cc_wb_arbiter_mux.sv
// N-source writeback-bus selector: arbitrates among holding requesters,
// registers the winning data/address/index and presents it with valid/ready
// toward the register-file write port. A slot is free when empty or being
// consumed, so a new entry can replace an accepted one with no bubble.
// Build option: define CC_WB_FIXED_PRIORITY_EN for fixed lowest-index-wins
// priority (no round-robin pointer); default is round-robin.
module cc_wb_arbiter_mux
  import cc_wb_pkg::*;
#(
  parameter int DATAWIDTH_BUS = CC_WB_DATAWIDTH,
  parameter int NUM_SOURCES   = 4,
  parameter int REGADDR_WIDTH = CC_WB_REGADDR_WIDTH,
  parameter int SRC_WIDTH     = $clog2(NUM_SOURCES)
) (
  input  logic                                   CC_WB_CLOCK_50,
  input  logic                                   CC_WB_RESET_InLow,
  input  logic [NUM_SOURCES-1:0]                 CC_WB_req_InBUS,
  input  logic [NUM_SOURCES*DATAWIDTH_BUS-1:0]   CC_WB_data_InBUS,
  input  logic [NUM_SOURCES*REGADDR_WIDTH-1:0]   CC_WB_addr_InBUS,
  output logic [NUM_SOURCES-1:0]                 CC_WB_grant_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]               CC_WB_data_OutBUS,
  output logic [REGADDR_WIDTH-1:0]               CC_WB_addr_OutBUS,
  output logic [SRC_WIDTH-1:0]                   CC_WB_src_OutBUS,
  output logic                                   CC_WB_valid_Out,
  input  logic                                   CC_WB_ready_In
);

  wb_state_e                r_state;
  wb_state_e                w_state_nxt;
  logic [DATAWIDTH_BUS-1:0] r_data;
  logic [REGADDR_WIDTH-1:0] r_addr;
  logic [SRC_WIDTH-1:0]     r_src;
  logic [SRC_WIDTH-1:0]     w_ptr;
  logic [NUM_SOURCES-1:0]   w_arb_grant;
  logic [SRC_WIDTH-1:0]     w_arb_idx;
  logic                     w_free;
  logic                     w_grant_any;
  logic [DATAWIDTH_BUS-1:0] w_sel_data;
  logic [REGADDR_WIDTH-1:0] w_sel_addr;

  assign w_free = (r_state == WB_EMPTY) || CC_WB_ready_In;

`ifdef CC_WB_FIXED_PRIORITY_EN
  // Fixed priority: scan always starts at source 0 (memory beats ALU).
  assign w_ptr = '0;
`else
  logic [SRC_WIDTH-1:0] r_ptr;
  assign w_ptr = r_ptr;

  // Advance the round-robin start just past the granted source.
  always_ff @(posedge CC_WB_CLOCK_50 or negedge CC_WB_RESET_InLow) begin
    if (!CC_WB_RESET_InLow) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      r_ptr <= SRC_WIDTH'(wrap_inc(int'(w_arb_idx), NUM_SOURCES));
    end
  end
`endif

  cc_rr_arbiter #(
    .NUM_SOURCES (NUM_SOURCES),
    .SRC_WIDTH   (SRC_WIDTH)
  ) u_arb (
    .i_req   (CC_WB_req_InBUS),
    .i_ptr   (w_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx)
  );

  // Grant only into a free slot, and never while reset is held.
  always_comb begin
    CC_WB_grant_OutBUS = '0;
    if (CC_WB_RESET_InLow && w_free) begin
      CC_WB_grant_OutBUS = w_arb_grant;
    end
  end

  assign w_grant_any = |CC_WB_grant_OutBUS;

  // One-hot mux of the granted source's data and destination address.
  always_comb begin
    w_sel_data = '0;
    w_sel_addr = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_arb_grant[i]) begin
        w_sel_data = CC_WB_data_InBUS[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
        w_sel_addr = CC_WB_addr_InBUS[i*REGADDR_WIDTH +: REGADDR_WIDTH];
      end
    end
  end

  // Output-slot state register.
  always_ff @(posedge CC_WB_CLOCK_50 or negedge CC_WB_RESET_InLow) begin
    if (!CC_WB_RESET_InLow) begin
      r_state <= WB_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A grant fills the slot; otherwise an accepted entry empties it; a stall holds.
  always_comb begin
    w_state_nxt = r_state;
    if (w_grant_any) begin
      w_state_nxt = WB_FULL;
    end else if (CC_WB_ready_In) begin
      w_state_nxt = WB_EMPTY;
    end
  end

  // Capture the winning entry; it overwrites any entry consumed this cycle.
  always_ff @(posedge CC_WB_CLOCK_50 or negedge CC_WB_RESET_InLow) begin
    if (!CC_WB_RESET_InLow) begin
      r_data <= '0;
      r_addr <= '0;
      r_src  <= '0;
    end else if (w_grant_any) begin
      r_data <= w_sel_data;
      r_addr <= w_sel_addr;
      r_src  <= w_arb_idx;
    end
  end

  assign CC_WB_data_OutBUS = r_data;
  assign CC_WB_addr_OutBUS = r_addr;
  assign CC_WB_src_OutBUS  = r_src;
  assign CC_WB_valid_Out   = (r_state == WB_FULL);

endmodule
